// File: rtl/meas_pkg.sv
// Shared definitions for the windowed measurement stages: FSM encoding and width helpers.
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_SAMPLE,
        ST_OUTPUT
    } meas_state_t;

    // max - min needs one extra bit to hold the full signed span.
    function automatic int diff_width(input int data_width);
        return data_width + 1;
    endfunction

    // Summing 2^avg_log2 non-negative differences can never overflow this width.
    function automatic int acc_width(input int data_width, input int avg_log2);
        return data_width + 1 + avg_log2;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/meas_win_timer.sv
// Window timer shared by the measurement stages: counts 0..range, pulses win_done at the end
// of each window and restarts from 0 whenever range changes.
module meas_win_timer
    import meas_pkg::*;
#(
    parameter int RANGE_WIDTH = 10
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [RANGE_WIDTH-1:0] range,
    output logic                   win_done,
    output logic                   restart
);

    logic [RANGE_WIDTH-1:0] cnt;
    logic [RANGE_WIDTH-1:0] range_q;

    // A change of range (including 0 -> nonzero) opens a fresh window next cycle.
    assign restart  = (range != range_q);
    assign win_done = (range != '0) && !restart && (cnt == range);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            range_q <= '0;
        end else begin
            range_q <= range;
            if ((range == '0) || restart || (cnt == range)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/amp_avg_meas.sv
// Averaged peak-to-peak amplitude of the windowed max/min stages, one result per 2^AVG_LOG2 windows.
// Optional threshold alarm enabled by defining AMP_ALARM_EN.
module amp_avg_meas
    import meas_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int RANGE_WIDTH = 10,
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE_DLY  = 3
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic [RANGE_WIDTH-1:0]       range,
    input  logic signed [DATA_WIDTH-1:0] max_in,
    input  logic signed [DATA_WIDTH-1:0] min_in,
`ifdef AMP_ALARM_EN
    input  logic [DATA_WIDTH:0]          thresh,
    output logic                         amp_alarm,
`endif
    output logic [DATA_WIDTH:0]          amp_out,
    output logic                         amp_valid,
    output logic                         win_done
);

    localparam int DIFF_W   = diff_width(DATA_WIDTH);
    localparam int ACC_W    = acc_width(DATA_WIDTH, AVG_LOG2);
    localparam int IDX_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int DLY_W    = cnt_width(SETTLE_DLY);
    localparam int DLY_LOAD = (SETTLE_DLY > 0) ? SETTLE_DLY - 1 : 0;
    localparam int LAST_IDX = (1 << AVG_LOG2) - 1;
    // With no settle delay the sample is taken straight after the window end.
    localparam meas_state_t ST_AFTER_WIN = (SETTLE_DLY > 0) ? ST_SETTLE : ST_SAMPLE;

    function automatic logic [DIFF_W-1:0] clamp_pos(input logic signed [DIFF_W-1:0] d);
        return d[DIFF_W-1] ? '0 : $unsigned(d);
    endfunction

    meas_state_t state, state_next;
    logic        restart;
    logic        clear;
    logic        load_dly;
    logic        do_sample;
    logic        last;

    logic [DLY_W-1:0] dly;
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] acc;

    logic signed [DIFF_W-1:0] diff_p0;
    logic [DIFF_W-1:0]        mag_p0;
    logic [ACC_W-1:0]         sum_p0;
    logic [DIFF_W-1:0]        avg_p0;

    meas_win_timer #(
        .RANGE_WIDTH(RANGE_WIDTH)
    ) u_timer (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .range   (range),
        .win_done(win_done),
        .restart (restart)
    );

    // Stage p0: difference, clamp and running sum, all resolved within the SAMPLE cycle.
    assign diff_p0 = DIFF_W'(max_in) - DIFF_W'(min_in);
    assign mag_p0  = clamp_pos(diff_p0);
    assign sum_p0  = acc + ACC_W'(mag_p0);
    assign avg_p0  = sum_p0[ACC_W-1:AVG_LOG2];
    assign last    = (idx == IDX_W'(LAST_IDX));

    assign amp_valid = (state == ST_OUTPUT);

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        load_dly   = 1'b0;
        do_sample  = 1'b0;
        if (range == '0) begin
            state_next = ST_IDLE;
            clear      = 1'b1;
        end else if (restart) begin
            state_next = ST_RUN;
            clear      = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (win_done) begin
                        state_next = ST_AFTER_WIN;
                        load_dly   = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (dly == '0) begin
                        state_next = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    do_sample = 1'b1;
                    if (last) begin
                        state_next = ST_OUTPUT;
                    end else if (win_done) begin
                        state_next = ST_AFTER_WIN;
                        load_dly   = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
                ST_OUTPUT: begin
                    // Short windows can end while the result is being presented.
                    if (win_done) begin
                        state_next = ST_AFTER_WIN;
                        load_dly   = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dly   <= '0;
        end else begin
            state <= state_next;
            if (load_dly) begin
                dly <= DLY_W'(DLY_LOAD);
            end else if ((state == ST_SETTLE) && (dly != '0)) begin
                dly <= dly - 1'b1;
            end
        end
    end

    // Stage p1: accumulator, window index and the published average.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            idx     <= '0;
            amp_out <= '0;
        end else if (clear) begin
            acc <= '0;
            idx <= '0;
        end else if (do_sample) begin
            if (last) begin
                acc     <= '0;
                idx     <= '0;
                amp_out <= avg_p0;
            end else begin
                acc <= sum_p0;
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef AMP_ALARM_EN
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            amp_alarm <= 1'b0;
        end else if (range == '0) begin
            amp_alarm <= 1'b0;
        end else if (do_sample && last && !clear) begin
            amp_alarm <= (avg_p0 > thresh);
        end
    end
`endif

    // The sample must land before the next window closes.
    settle_fits_window: assert property (
        @(posedge clk_in) disable iff (!rst_n)
        (range != '0) |-> (int'(range) >= SETTLE_DLY)
    );

endmodule

// File: tb/tb_amp_avg_meas.sv
// Scoreboard bench for amp_avg_meas; alarm scenario runs when AMP_ALARM_EN is defined.
module tb_amp_avg_meas;

    localparam int DATA_WIDTH  = 12;
    localparam int RANGE_WIDTH = 10;
    localparam int AVG_LOG2    = 2;
    localparam int SETTLE_DLY  = 3;
    localparam int NAVG        = 1 << AVG_LOG2;

    logic                         clk_in = 1'b0;
    logic                         rst_n  = 1'b0;
    logic [RANGE_WIDTH-1:0]       range  = '0;
    logic signed [DATA_WIDTH-1:0] max_in = '0;
    logic signed [DATA_WIDTH-1:0] min_in = '0;
    logic [DATA_WIDTH:0]          amp_out;
    logic                         amp_valid;
    logic                         win_done;
`ifdef AMP_ALARM_EN
    logic [DATA_WIDTH:0]          thresh = '0;
    logic                         amp_alarm;
`endif

    int total = 0;
    int bad   = 0;
    int vcount = 0;
    int exp_q[$];

    amp_avg_meas #(
        .DATA_WIDTH (DATA_WIDTH),
        .RANGE_WIDTH(RANGE_WIDTH),
        .AVG_LOG2   (AVG_LOG2),
        .SETTLE_DLY (SETTLE_DLY)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .range    (range),
        .max_in   (max_in),
        .min_in   (min_in),
`ifdef AMP_ALARM_EN
        .thresh   (thresh),
        .amp_alarm(amp_alarm),
`endif
        .amp_out  (amp_out),
        .amp_valid(amp_valid),
        .win_done (win_done)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (amp_valid === 1'b1) vcount++;
    end

    function automatic int amp_model(input int mx, input int mn);
        return (mx - mn < 0) ? 0 : mx - mn;
    endfunction

    function automatic int first_lat(input int r);
        return NAVG * (r + 1) + SETTLE_DLY + 2;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wait_valid(input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < bound && !ok) begin
            tick();
            n++;
            if (amp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_win(input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < bound && !ok) begin
            tick();
            n++;
            if (win_done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic restart(input int r, input int mx, input int mn);
        range = '0;
        tick(2);
        max_in = DATA_WIDTH'(mx);
        min_in = DATA_WIDTH'(mn);
        range  = RANGE_WIDTH'(r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        range = '0;
        tick(2);
        total++;
        if (amp_out !== '0) begin bad++; $display("FAIL reset_amp got=%0d want=0", amp_out); end
        total++;
        if (amp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", amp_valid); end
        total++;
        if (win_done !== 1'b0) begin bad++; $display("FAIL reset_win got=%b want=0", win_done); end
        rst_n = 1'b1;
        tick(3);
        total++;
        if (amp_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", amp_valid); end
    endtask

    task automatic test_constant();
        int n;
        bit ok;
        int e;
        for (int i = 0; i < 3; i++) exp_q.push_back(amp_model(100, -50));
        restart(9, 100, -50);
        for (int i = 0; i < 3; i++) begin
            wait_valid(100, n, ok);
            e = (i == 0) ? first_lat(9) : NAVG * 10;
            total++;
            if (!ok || n != e) begin bad++; $display("FAIL const_interval%0d got=%0d want=%0d", i, n, e); end
            e = exp_q.pop_front();
            total++;
            if (amp_out !== (DATA_WIDTH + 1)'(e)) begin bad++; $display("FAIL const_amp%0d got=%0d want=%0d", i, amp_out, e); end
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        bit ok;
        int e;
        tick(17);
        rst_n = 1'b0;
        #1;
        total++;
        if (amp_out !== '0) begin bad++; $display("FAIL midreset_amp got=%0d want=0", amp_out); end
        total++;
        if (amp_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", amp_valid); end
        tick(3);
        rst_n = 1'b1;
        exp_q.push_back(amp_model(100, -50));
        wait_valid(100, n, ok);
        total++;
        if (!ok || n != first_lat(9)) begin bad++; $display("FAIL midreset_latency got=%0d want=%0d", n, first_lat(9)); end
        e = exp_q.pop_front();
        total++;
        if (amp_out !== (DATA_WIDTH + 1)'(e)) begin bad++; $display("FAIL midreset_amp2 got=%0d want=%0d", amp_out, e); end
    endtask

    task automatic test_diffs();
        int d[4];
        int n;
        bit ok;
        int sum;
        int e;
        d[0] = 10; d[1] = 11; d[2] = 12; d[3] = 14;
        sum = 0;
        for (int k = 0; k < 4; k++) sum += d[k];
        exp_q.push_back(sum >> AVG_LOG2);
        restart(9, d[0] - 20, -20);
        for (int k = 0; k < 4; k++) begin
            wait_win(30, n, ok);
            e = (k == 0) ? 10 : 4;
            total++;
            if (!ok || n != e) begin bad++; $display("FAIL diffs_win%0d got=%0d want=%0d", k, n, e); end
            if (k < 3) begin
                tick(6);
                max_in = DATA_WIDTH'(d[k + 1] - 20);
            end
        end
        wait_valid(30, n, ok);
        total++;
        if (!ok || n != SETTLE_DLY + 2) begin bad++; $display("FAIL diffs_latency got=%0d want=%0d", n, SETTLE_DLY + 2); end
        e = exp_q.pop_front();
        total++;
        if (amp_out !== (DATA_WIDTH + 1)'(e)) begin bad++; $display("FAIL diffs_amp got=%0d want=%0d", amp_out, e); end
    endtask

    task automatic test_extremes();
        int n;
        bit ok;
        int e;
        exp_q.push_back(amp_model(-5, 3));
        restart(9, -5, 3);
        wait_valid(100, n, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || amp_out !== (DATA_WIDTH + 1)'(e)) begin bad++; $display("FAIL neg_clamp got=%0d want=%0d", amp_out, e); end
        exp_q.push_back(amp_model(2047, -2048));
        restart(9, 2047, -2048);
        wait_valid(100, n, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || amp_out !== (DATA_WIDTH + 1)'(e)) begin bad++; $display("FAIL full_scale got=%0d want=%0d", amp_out, e); end
    endtask

    task automatic test_range_change();
        int n;
        bit ok;
        int v0;
        int e;
        restart(9, 60, 0);
        for (int k = 0; k < 2; k++) wait_win(30, n, ok);
        tick(3);
        v0 = vcount;
        range = '0;
        tick(60);
        total++;
        if (vcount != v0) begin bad++; $display("FAIL disabled_valids got=%0d want=%0d", vcount, v0); end
        total++;
        if (amp_out !== 13'd4095) begin bad++; $display("FAIL disabled_hold got=%0d want=4095", amp_out); end
        total++;
        if (win_done !== 1'b0) begin bad++; $display("FAIL disabled_win got=%b want=0", win_done); end
        exp_q.push_back(amp_model(60, 0));
        range = 10'd9;
        wait_valid(100, n, ok);
        total++;
        if (!ok || n != first_lat(9)) begin bad++; $display("FAIL reenable_latency got=%0d want=%0d", n, first_lat(9)); end
        e = exp_q.pop_front();
        total++;
        if (amp_out !== (DATA_WIDTH + 1)'(e)) begin bad++; $display("FAIL reenable_amp got=%0d want=%0d", amp_out, e); end
        max_in = 12'sd200;
        for (int k = 0; k < 2; k++) wait_win(30, n, ok);
        tick(3);
        range  = 10'd15;
        max_in = 12'sd80;
        exp_q.push_back(amp_model(80, 0));
        wait_valid(200, n, ok);
        total++;
        if (!ok || n != first_lat(15)) begin bad++; $display("FAIL rechange_latency got=%0d want=%0d", n, first_lat(15)); end
        e = exp_q.pop_front();
        total++;
        if (amp_out !== (DATA_WIDTH + 1)'(e)) begin bad++; $display("FAIL rechange_amp got=%0d want=%0d", amp_out, e); end
    endtask

`ifdef AMP_ALARM_EN
    task automatic test_alarm();
        int n;
        bit ok;
        int e;
        thresh = 13'd150;
        exp_q.push_back(amp_model(100, -50));
        restart(9, 100, -50);
        wait_valid(100, n, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || amp_out !== (DATA_WIDTH + 1)'(e) || amp_alarm !== 1'b0) begin
            bad++; $display("FAIL alarm_eq amp=%0d alarm=%b want amp=%0d alarm=0", amp_out, amp_alarm, e);
        end
        exp_q.push_back(amp_model(101, -50));
        restart(9, 101, -50);
        wait_valid(100, n, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || amp_out !== (DATA_WIDTH + 1)'(e) || amp_alarm !== 1'b1) begin
            bad++; $display("FAIL alarm_above amp=%0d alarm=%b want amp=%0d alarm=1", amp_out, amp_alarm, e);
        end
        tick(5);
        total++;
        if (amp_alarm !== 1'b1) begin bad++; $display("FAIL alarm_hold got=%b want=1", amp_alarm); end
        range = '0;
        tick(2);
        total++;
        if (amp_alarm !== 1'b0) begin bad++; $display("FAIL alarm_clear got=%b want=0", amp_alarm); end
    endtask
`endif

    initial begin
        test_reset();
        test_constant();
        test_reset_midrun();
        test_diffs();
        test_extremes();
        test_range_change();
`ifdef AMP_ALARM_EN
        test_alarm();
`endif
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
